// File: rtl/muldiv_unit_if.sv
// Pipeline-side bundle for the iterative multiply/divide unit: EX-stage instruction
// fields in, HI/LO state, stall and read-back result out.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       aluOp;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] result;

    modport master (
        output start, aluOp, funct, rs_data, rt_data,
        input  busy, done, stall, hi, lo, result
    );

    modport slave (
        input  start, aluOp, funct, rs_data, rt_data,
        output busy, done, stall, hi, lo, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu engine with HI/LO registers and mfhi/mflo/mthi/mtlo.
// Define MULDIV_RADIX4_EN to retire two multiplier bits per cycle (divide unchanged).
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input logic           clk,
    input logic           reset,
    muldiv_unit_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [CNT_W-1:0] LastDiv = CNT_W'(WIDTH - 1);
`ifdef MULDIV_RADIX4_EN
    localparam logic [CNT_W-1:0] LastMul = CNT_W'(WIDTH / 2 - 1);
`else
    localparam logic [CNT_W-1:0] LastMul = CNT_W'(WIDTH - 1);
`endif

    // Magnitude of a value that is two's complement only when sgn is set.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    // One shift-add step: acc = {partial product high, remaining multiplier bits}.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0]   mcand);
        logic [WIDTH:0] sum;
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        return {sum, acc[WIDTH-1:1]};
    endfunction

    // One restoring step: acc = {partial remainder, dividend bits shifting into quotient}.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0]   dvsr);
        logic [WIDTH:0]   shifted;
        logic [WIDTH+1:0] diff;
        shifted = acc[2*WIDTH-1:WIDTH-1];
        diff    = {1'b0, shifted} - {2'b00, dvsr};
        if (diff[WIDTH+1]) begin
            return {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
        return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic is_rtype;
    logic op_mfhi, op_mthi, op_mflo, op_mtlo;
    logic op_mult, op_multu, op_div, op_divu;
    logic is_arith, is_muldiv;

    always_comb begin
        is_rtype  = (bus.aluOp == 2'b10);
        op_mfhi   = is_rtype && (bus.funct == 6'b010000);
        op_mthi   = is_rtype && (bus.funct == 6'b010001);
        op_mflo   = is_rtype && (bus.funct == 6'b010010);
        op_mtlo   = is_rtype && (bus.funct == 6'b010011);
        op_mult   = is_rtype && (bus.funct == 6'b011000);
        op_multu  = is_rtype && (bus.funct == 6'b011001);
        op_div    = is_rtype && (bus.funct == 6'b011010);
        op_divu   = is_rtype && (bus.funct == 6'b011011);
        is_arith  = op_mult || op_multu || op_div || op_divu;
        is_muldiv = is_arith || op_mfhi || op_mthi || op_mflo || op_mtlo;
    end

    logic [2*WIDTH-1:0] step_mul, step_div, step_sel, prod;
    logic [WIDTH-1:0]   quo, rem, fin_hi, fin_lo;
    logic [CNT_W-1:0]   last_iter;

    // Datapath for the current RUN cycle plus the sign-corrected final result.
    always_comb begin
        step_mul = mul_step(acc_q, opb_q);
`ifdef MULDIV_RADIX4_EN
        step_mul = mul_step(step_mul, opb_q);
`endif
        step_div  = div_step(acc_q, opb_q);
        step_sel  = is_div_q ? step_div : step_mul;
        last_iter = is_div_q ? LastDiv : LastMul;
        prod      = neg_q ? -step_mul : step_mul;
        quo       = step_div[WIDTH-1:0];
        rem       = step_div[2*WIDTH-1:WIDTH];
        fin_hi    = prod[2*WIDTH-1:WIDTH];
        fin_lo    = prod[WIDTH-1:0];
        if (is_div_q) begin
            if (div_zero_q) begin
                fin_hi = dvd_q;
                fin_lo = '1;
            end else begin
                fin_hi = neg_rem_q ? -rem : rem;
                fin_lo = neg_q ? -quo : quo;
            end
        end
    end

    logic sgn_op, a_neg, b_neg;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        dvd_d      = dvd_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        sgn_op     = op_mult || op_div;
        a_neg      = sgn_op && bus.rs_data[WIDTH-1];
        b_neg      = sgn_op && bus.rt_data[WIDTH-1];

        unique case (state_q)
            StIdle: begin
                if (bus.start && is_arith) begin
                    state_d    = StRun;
                    cnt_d      = '0;
                    is_div_d   = op_div || op_divu;
                    neg_d      = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div_zero_d = (bus.rt_data == '0);
                    dvd_d      = bus.rs_data;
                    if (op_div || op_divu) begin
                        acc_d = {{WIDTH{1'b0}}, mag(bus.rs_data, sgn_op)};
                        opb_d = mag(bus.rt_data, sgn_op);
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, mag(bus.rt_data, sgn_op)};
                        opb_d = mag(bus.rs_data, sgn_op);
                    end
                end else if (bus.start && op_mthi) begin
                    hi_d = bus.rs_data;
                end else if (bus.start && op_mtlo) begin
                    lo_d = bus.rs_data;
                end
            end
            StRun: begin
                acc_d = step_sel;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == last_iter) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    hi_d    = fin_hi;
                    lo_d    = fin_lo;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            dvd_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            dvd_q      <= dvd_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // In DONE only mfhi/mflo may proceed; anything that would touch HI/LO waits one more cycle.
    always_comb begin
        bus.busy   = (state_q != StIdle);
        bus.done   = (state_q == StDone);
        bus.hi     = hi_q;
        bus.lo     = lo_q;
        bus.result = op_mfhi ? hi_q : (op_mflo ? lo_q : '0);
        bus.stall  = bus.start && is_muldiv &&
                     ((state_q == StRun) ||
                      ((state_q == StDone) && !(op_mfhi || op_mflo)));
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int unsigned W = 32;
    localparam logic [5:0] FMfhi = 6'h10, FMthi = 6'h11, FMflo = 6'h12, FMtlo = 6'h13;
    localparam logic [5:0] FMult = 6'h18, FMultu = 6'h19, FDiv = 6'h1a, FDivu = 6'h1b;
    localparam logic [5:0] FAdd = 6'h20;
`ifdef MULDIV_RADIX4_EN
    localparam int MulLat = W / 2 + 1;
`else
    localparam int MulLat = W + 1;
`endif
    localparam int DivLat = W + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_hi, exp_lo;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic idle_inputs();
        bus.start   = 1'b0;
        bus.aluOp   = 2'b00;
        bus.funct   = 6'h00;
        bus.rs_data = '0;
        bus.rt_data = '0;
    endtask

    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start   = 1'b1;
        bus.aluOp   = 2'b10;
        bus.funct   = f;
        bus.rs_data = a;
        bus.rt_data = b;
    endtask

    // Reference: plain 64-bit / 32-bit integer arithmetic with the architectural corner rules.
    task automatic model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] mh, output logic [W-1:0] ml);
        longint p;
        longint unsigned pu;
        int sa, sb;
        mh = '0;
        ml = '0;
        if (f == FMult) begin
            p = longint'($signed(a)) * longint'($signed(b));
            {mh, ml} = p;
        end else if (f == FMultu) begin
            pu = {32'h0, a} * {32'h0, b};
            {mh, ml} = pu;
        end else if (b == 0) begin
            ml = '1;
            mh = a;
        end else if (f == FDiv) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                ml = 32'h8000_0000;
                mh = '0;
            end else begin
                sa = $signed(a);
                sb = $signed(b);
                ml = sa / sb;
                mh = sa % sb;
            end
        end else begin
            ml = a / b;
            mh = a % b;
        end
    endtask

    task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        int cyc;
        int lat;
        @(negedge clk);
        issue(f, a, b);
        @(negedge clk);
        idle_inputs();
        check_val("busy_run", bus.busy, 1);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 3 * W) begin
            @(negedge clk);
            cyc++;
        end
        model(f, a, b, exp_hi, exp_lo);
        lat = (f == FMult || f == FMultu) ? MulLat : DivLat;
        check_val("latency", cyc, lat);
        check_val("hi", bus.hi, exp_hi);
        check_val("lo", bus.lo, exp_lo);
        @(negedge clk);
        check_val("busy_after", bus.busy, 0);
        check_val("done_after", bus.done, 0);
    endtask

    task automatic read_back();
        issue(FMfhi, '0, '0);
        #1;
        check_val("mfhi", bus.result, exp_hi);
        check_val("mfhi_stall", bus.stall, 0);
        issue(FMflo, '0, '0);
        #1;
        check_val("mflo", bus.result, exp_lo);
        idle_inputs();
    endtask

    initial begin
        logic [5:0]   f;
        logic [W-1:0] a, b, h1;
        int           sel;
        bit           seen;

        idle_inputs();
        repeat (2) @(negedge clk);
        check_val("rst_hi", bus.hi, 0);
        check_val("rst_lo", bus.lo, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_stall", bus.stall, 0);
        reset = 1'b0;

        // Directed arithmetic corners.
        run_op(FMult, 32'd7, 32'hFFFF_FFFD);
        run_op(FMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(FDiv, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(FDiv, 32'hFFFF_FFF9, 32'd2);
        run_op(FDivu, 32'd7, 32'd0);
        run_op(FDiv, 32'hFFFF_FFF9, 32'd0);
        @(negedge clk);
        read_back();

        // Randomised operations with biased corner operands.
        for (int i = 0; i < 40; i++) begin
            f   = FMult + 6'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = '0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = W'($urandom_range(1, 15));
            if (sel == 3) a = W'($urandom_range(0, 15));
            run_op(f, a, b);
            read_back();
        end

        // Stall while busy; a mult presented mid-run is not accepted.
        @(negedge clk);
        issue(FMult, 32'd7, 32'hFFFF_FFFD);
        model(FMult, 32'd7, 32'hFFFF_FFFD, exp_hi, exp_lo);
        for (int cyc = 1; cyc <= MulLat - 1; cyc++) begin
            @(negedge clk);
            if (cyc == 5) issue(FMult, 32'd3, 32'd5);
            else issue(FMfhi, '0, '0);
            #1;
            check_val("stall_run", bus.stall, 1);
        end
        @(negedge clk);
        issue(FMfhi, '0, '0);
        #1;
        check_val("stall_done", bus.stall, 0);
        check_val("done_pulse", bus.done, 1);
        check_val("result_done", bus.result, exp_hi);
        @(negedge clk);
        idle_inputs();
        check_val("no_second_busy", bus.busy, 0);
        check_val("no_second_lo", bus.lo, exp_lo);

        // Moves to HI/LO and ignored instructions.
        @(negedge clk);
        issue(FMthi, 32'h1234_5678, '0);
        #1;
        check_val("mthi_busy", bus.busy, 0);
        check_val("mthi_stall", bus.stall, 0);
        @(negedge clk);
        idle_inputs();
        exp_hi = 32'h1234_5678;
        check_val("mthi_hi", bus.hi, exp_hi);
        check_val("mthi_busy2", bus.busy, 0);
        issue(FMtlo, 32'hCAFE_F00D, '0);
        @(negedge clk);
        idle_inputs();
        exp_lo = 32'hCAFE_F00D;
        check_val("mtlo_lo", bus.lo, exp_lo);
        read_back();
        issue(FAdd, 32'h1111_1111, 32'h2222_2222);
        #1;
        check_val("add_stall", bus.stall, 0);
        check_val("add_result", bus.result, 0);
        @(negedge clk);
        bus.aluOp = 2'b00;
        bus.funct = FMult;
        #1;
        check_val("nonrtype_stall", bus.stall, 0);
        @(negedge clk);
        idle_inputs();
        check_val("ignored_busy", bus.busy, 0);
        check_val("ignored_hi", bus.hi, exp_hi);
        check_val("ignored_lo", bus.lo, exp_lo);

        // Reset mid-divide aborts without a done pulse.
        @(negedge clk);
        issue(FDiv, 32'd100, 32'd7);
        @(negedge clk);
        idle_inputs();
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("abort_busy", bus.busy, 0);
        check_val("abort_hi", bus.hi, 0);
        check_val("abort_lo", bus.lo, 0);
        seen = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check_val("abort_no_done", seen, 0);
        run_op(FMult, 32'hFFFF_FFF0, 32'd12);
        h1 = exp_hi;
        check_val("post_reset_hi", bus.hi, h1);

        // Reset beats a simultaneous start.
        @(negedge clk);
        reset = 1'b1;
        issue(FMult, 32'd5, 32'd6);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        check_val("rst_start_busy", bus.busy, 0);
        check_val("rst_start_hi", bus.hi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers. It decodes aluOp/funct the same way as aluControl, but executes over multiple cycles. It sits beside the ALU in the EX stage and handles mult, multu, div, divu, mfhi, mflo, mthi and mtlo. It raises a stall to the pipeline while a result is not yet available.

Parameters:
WIDTH, 32, operand/HI/LO width in bits; must be even and >= 4
CNT_W, $clog2(WIDTH)+1, iteration counter width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  instruction valid in EX this cycle
aluOp  input  2  2'b10 = RTYPE; any other value means no muldiv op
funct  input  6  R-type funct field
rs_data  input  WIDTH  operand A (multiplicand / dividend / mthi/mtlo source)
rt_data  input  WIDTH  operand B (multiplier / divisor)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when HI/LO are updated by mult/div
stall  output  1  combinational; request pipeline freeze
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
result  output  WIDTH  combinational; hi for mfhi, lo for mflo, else 0

Behaviour:
- funct decode, only when aluOp==2'b10:
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011
  - mult 011000, multu 011001, div 011010, divu 011011
  - Other funct values or aluOp values are ignored: no state change, stall=0.
- Reset: state=IDLE, hi=0, lo=0, counter=0, internal accumulators=0, busy=0, done=0.
  - Reset mid-operation aborts the op; no done pulse follows.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE->RUN: start & mult/multu/div/divu. Operands are latched at that edge (cycle 0).
  - RUN: one iteration per cycle for WIDTH cycles. Multiply is shift-add; divide is restoring shift-subtract.
  - RUN->DONE: after the WIDTH-th iteration. hi/lo are written on that same edge.
  - DONE->IDLE: unconditional after 1 cycle. done=1 only in DONE, which is WIDTH+1 cycles after the accept edge.
- start while busy: a new mult/div is not accepted.
  - stall=1 for any decoded muldiv funct while busy, so the pipeline holds and re-presents the instruction.
  - stall=0 for non-muldiv instructions.
- mthi/mtlo in IDLE: hi (resp. lo) <= rs_data at the next edge, single cycle, busy stays 0.
- mfhi/mflo in IDLE: result is the current hi/lo, same cycle.
  - In DONE, result already reflects the new values and stall=0.
- Arithmetic:
  - mult/multu: full 2*WIDTH product; hi = upper half, lo = lower half.
  - Signed ops work on magnitudes, then apply sign correction.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- Divide by zero (div or divu): lo = all ones, hi = rs_data. Full latency still applies.
- Signed overflow (div of MIN by -1): lo = MIN, hi = 0.
- Simultaneous reset & start: reset wins.

Optional Feature:
MULDIV_RADIX4_EN
- Defined: multiply retires 2 multiplier bits per cycle, so RUN lasts WIDTH/2 cycles and done comes WIDTH/2+1 cycles after accept. Divide is unchanged.
- Undefined: multiply takes WIDTH iterations, identical to divide. Results are bit-identical in both modes.

Test Plan:
- WIDTH=32, mult rs=7 rt=0xFFFFFFFD -> done at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- multu rs=0xFFFFFFFF rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- div rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu rs=7 rt=0 -> lo=0xFFFFFFFF, hi=7.
- Start mult, then hold mfhi with start=1 from cycle 1:
  - stall=1 through cycle 32; stall=0 and result=new hi at cycle 33.
  - A second mult issued at cycle 5 is not accepted.
- mthi rs=0x12345678, then mflo/mfhi -> hi=0x12345678 after one edge, busy never asserted; add (funct 100000) -> stall=0, no change.
- Start div, assert reset at cycle 10 -> from next edge busy=0, hi=lo=0, done stays 0; a new mult accepted immediately after reset completes correctly.
